// File: rtl/mbc_ctrl_pkg.sv
// rtl/mbc_ctrl_pkg.sv - shared encodings for the accumulator-machine control unit
package mbc_ctrl_pkg;

  // Bus source selects; 0 leaves the bus undriven/idle
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  // ALU operation selects
  localparam logic [2:0] ALU_AND     = 3'd0;
  localparam logic [2:0] ALU_ADD     = 3'd1;
  localparam logic [2:0] ALU_PASS_DR = 3'd2;
  localparam logic [2:0] ALU_CMA     = 3'd3;
  localparam logic [2:0] ALU_CIR     = 3'd4;
  localparam logic [2:0] ALU_CIL     = 3'd5;

  // Opcodes decoded from IR[14:12]
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // Register-reference bit positions within IR[11:0]
  localparam int RR_HLT = 0;
  localparam int RR_SZE = 1;
  localparam int RR_SZA = 2;
  localparam int RR_SNA = 3;
  localparam int RR_SPA = 4;
  localparam int RR_INC = 5;
  localparam int RR_CIL = 6;
  localparam int RR_CIR = 7;
  localparam int RR_CME = 8;
  localparam int RR_CMA = 9;
  localparam int RR_CLE = 10;
  localparam int RR_CLA = 11;

  // I/O bit positions within IR[11:0]
  localparam int IO_IOF = 6;
  localparam int IO_ION = 7;
  localparam int IO_SKO = 8;
  localparam int IO_SKI = 9;

  // Sequence-counter timing states
  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
  } t_state_e;

  // Isolate the lowest set bit so only one register-ref micro-op fires
  function automatic logic [11:0] lowest_bit(input logic [11:0] v);
    return v & (~v + 12'd1);
  endfunction

endpackage

// File: rtl/control_unit_seq_counter.sv
// rtl/control_unit_seq_counter.sv - 3-bit sequence counter with clear/increment/hold
module seq_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       incr_i,
  output logic [2:0] sc_o
);

  logic [2:0] sc_q, sc_d;

  // Clear wins over increment; otherwise hold
  always_comb begin
    sc_d = sc_q;
    if (clr_i)       sc_d = 3'd0;
    else if (incr_i) sc_d = sc_q + 3'd1;
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sc_q <= 3'd0;
    else          sc_q <= sc_d;
  end

  assign sc_o = sc_q;

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/decode/execute sequencer; interrupt support under MBC_INTERRUPT_EN
module control_unit
  import mbc_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] IR_out,
  input  logic [DATA_W-1:0] AC_out,
  input  logic [DATA_W-1:0] DR_out,
  input  logic              E_out,
  input  logic              IEN_out,
`ifdef MBC_INTERRUPT_EN
  input  logic              FGI,
  input  logic              FGO,
`endif
  output logic [2:0]        bus_sel,
  output logic [2:0]        alu_sel,
  output logic              AR_load,
  output logic              PC_load,
  output logic              DR_load,
  output logic              AC_load,
  output logic              IR_load,
  output logic              TR_load,
  output logic              E_load,
  output logic              IEN_load,
  output logic              AR_incr,
  output logic              PC_incr,
  output logic              DR_incr,
  output logic              AC_incr,
  output logic              E_incr,
  output logic              AR_reset,
  output logic              PC_reset,
  output logic              AC_reset,
  output logic              E_reset,
  output logic              IEN_reset,
  output logic              memory_write,
  output logic              halted,
  output logic [2:0]        sc_out
);

  logic [2:0]  sc;
  t_state_e    state;
  logic        sc_clr, sc_incr;
  logic        i_q, i_d;
  logic        halted_q, halted_d;
  logic [11:0] rr;
  logic        d7;
  logic [2:0]  op;
`ifdef MBC_INTERRUPT_EN
  logic        r_q, r_d;
`else
  logic        unused_ien;
  assign unused_ien = IEN_out;
`endif

  seq_counter u_sc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (sc_clr),
    .incr_i  (sc_incr),
    .sc_o    (sc)
  );

  assign state  = t_state_e'(sc);
  assign op     = IR_out[DATA_W-2:DATA_W-4];
  assign d7     = (op == OP_REG);
  assign rr     = lowest_bit(IR_out[ADDR_W-1:0]);
  assign sc_out = sc;
  assign halted = halted_q;

  // Indirect-bit latch, sticky halt and pending-interrupt flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_q      <= 1'b0;
      halted_q <= 1'b0;
`ifdef MBC_INTERRUPT_EN
      r_q      <= 1'b0;
`endif
    end else begin
      i_q      <= i_d;
      halted_q <= halted_d;
`ifdef MBC_INTERRUPT_EN
      r_q      <= r_d;
`endif
    end
  end

  // Decode current timing state and instruction into datapath strobes
  always_comb begin
    bus_sel = BUS_NONE;  alu_sel = ALU_AND;
    AR_load = 1'b0;  PC_load = 1'b0;  DR_load = 1'b0;  AC_load = 1'b0;
    IR_load = 1'b0;  TR_load = 1'b0;  E_load  = 1'b0;  IEN_load = 1'b0;
    AR_incr = 1'b0;  PC_incr = 1'b0;  DR_incr = 1'b0;  AC_incr = 1'b0;  E_incr = 1'b0;
    AR_reset = 1'b0; PC_reset = 1'b0; AC_reset = 1'b0; E_reset = 1'b0;  IEN_reset = 1'b0;
    memory_write = 1'b0;
    sc_clr = 1'b0;  sc_incr = 1'b0;
    i_d = i_q;  halted_d = halted_q;
`ifdef MBC_INTERRUPT_EN
    r_d = r_q;
`endif
    if (!reset_n) begin
      AR_reset = 1'b1; PC_reset = 1'b1; AC_reset = 1'b1; E_reset = 1'b1; IEN_reset = 1'b1;
    end else if (halted_q) begin
      // frozen until reset
    end
`ifdef MBC_INTERRUPT_EN
    else if (r_q && (state inside {T0, T1, T2})) begin
      sc_incr = 1'b1;
      case (state)
        T0: begin AR_reset = 1'b1; bus_sel = BUS_PC; TR_load = 1'b1; end
        T1: begin bus_sel = BUS_TR; memory_write = 1'b1; PC_reset = 1'b1; end
        default: begin PC_incr = 1'b1; IEN_reset = 1'b1; r_d = 1'b0; sc_clr = 1'b1; end
      endcase
    end
`endif
    else begin
      sc_incr = 1'b1;
      case (state)
        T0: begin bus_sel = BUS_PC; AR_load = 1'b1; end
        T1: begin bus_sel = BUS_MEM; IR_load = 1'b1; PC_incr = 1'b1; end
        T2: begin bus_sel = BUS_IR; AR_load = 1'b1; i_d = IR_out[DATA_W-1]; end
        T3: begin
          if (d7) begin
            sc_clr = 1'b1;
            if (!i_q) begin
              if (rr[RR_CLA]) AC_reset = 1'b1;
              if (rr[RR_CLE]) E_reset = 1'b1;
              if (rr[RR_CMA]) begin alu_sel = ALU_CMA; AC_load = 1'b1; end
              if (rr[RR_CME]) E_incr = 1'b1;
              if (rr[RR_CIR]) begin alu_sel = ALU_CIR; AC_load = 1'b1; E_load = 1'b1; end
              if (rr[RR_CIL]) begin alu_sel = ALU_CIL; AC_load = 1'b1; E_load = 1'b1; end
              if (rr[RR_INC]) AC_incr = 1'b1;
              if (rr[RR_SPA] && !AC_out[DATA_W-1]) PC_incr = 1'b1;
              if (rr[RR_SNA] &&  AC_out[DATA_W-1]) PC_incr = 1'b1;
              if (rr[RR_SZA] && (AC_out == '0))    PC_incr = 1'b1;
              if (rr[RR_SZE] && !E_out)            PC_incr = 1'b1;
              if (rr[RR_HLT]) halted_d = 1'b1;
            end
`ifdef MBC_INTERRUPT_EN
            else begin
              if (IR_out[IO_ION]) IEN_load = 1'b1;
              if (IR_out[IO_IOF]) IEN_reset = 1'b1;
              if (IR_out[IO_SKI] && FGI) PC_incr = 1'b1;
              if (IR_out[IO_SKO] && FGO) PC_incr = 1'b1;
            end
`endif
          end else if (i_q) begin
            bus_sel = BUS_MEM; AR_load = 1'b1;
          end
        end
        T4: begin
          case (op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin bus_sel = BUS_MEM; DR_load = 1'b1; end
            OP_STA: begin bus_sel = BUS_AC; memory_write = 1'b1; sc_clr = 1'b1; end
            OP_BUN: begin bus_sel = BUS_AR; PC_load = 1'b1; sc_clr = 1'b1; end
            OP_BSA: begin bus_sel = BUS_PC; memory_write = 1'b1; AR_incr = 1'b1; end
            default: sc_clr = 1'b1;
          endcase
        end
        T5: begin
          case (op)
            OP_AND: begin alu_sel = ALU_AND; AC_load = 1'b1; sc_clr = 1'b1; end
            OP_ADD: begin alu_sel = ALU_ADD; AC_load = 1'b1; E_load = 1'b1; sc_clr = 1'b1; end
            OP_LDA: begin alu_sel = ALU_PASS_DR; AC_load = 1'b1; sc_clr = 1'b1; end
            OP_BSA: begin bus_sel = BUS_AR; PC_load = 1'b1; sc_clr = 1'b1; end
            OP_ISZ: DR_incr = 1'b1;
            default: sc_clr = 1'b1;
          endcase
        end
        T6: begin
          sc_clr = 1'b1;
          if (op == OP_ISZ) begin
            bus_sel = BUS_DR; memory_write = 1'b1;
            if (DR_out == '0) PC_incr = 1'b1;
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end
`ifdef MBC_INTERRUPT_EN
    if (reset_n && !halted_q && !(state inside {T0, T1, T2}) && IEN_out && (FGI || FGO))
      r_d = 1'b1;
`endif
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - control_unit with a behavioural datapath and memory, directed programs
module tb_control_unit;
  import mbc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] ir, ac, dr, tr;
  logic [11:0] ar, pc;
  logic        e, ien;
  logic [15:0] mem [0:4095];
  logic [15:0] bus, alu_res;
  logic        alu_c;
  logic        ld_we = 1'b0, ld_ac = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [15:0] ld_data = '0, ld_ac_val = '0;
`ifdef MBC_INTERRUPT_EN
  logic        fgi = 1'b0, fgo = 1'b0;
`endif

  logic [2:0] bus_sel, alu_sel, sc_out;
  logic AR_load, PC_load, DR_load, AC_load, IR_load, TR_load, E_load, IEN_load;
  logic AR_incr, PC_incr, DR_incr, AC_incr, E_incr;
  logic AR_reset, PC_reset, AC_reset, E_reset, IEN_reset;
  logic memory_write, halted;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset_n(reset_n),
    .IR_out(ir), .AC_out(ac), .DR_out(dr), .E_out(e), .IEN_out(ien),
`ifdef MBC_INTERRUPT_EN
    .FGI(fgi), .FGO(fgo),
`endif
    .bus_sel(bus_sel), .alu_sel(alu_sel),
    .AR_load(AR_load), .PC_load(PC_load), .DR_load(DR_load), .AC_load(AC_load),
    .IR_load(IR_load), .TR_load(TR_load), .E_load(E_load), .IEN_load(IEN_load),
    .AR_incr(AR_incr), .PC_incr(PC_incr), .DR_incr(DR_incr), .AC_incr(AC_incr), .E_incr(E_incr),
    .AR_reset(AR_reset), .PC_reset(PC_reset), .AC_reset(AC_reset), .E_reset(E_reset),
    .IEN_reset(IEN_reset), .memory_write(memory_write), .halted(halted), .sc_out(sc_out)
  );

  // Bus multiplexer and ALU of the reference datapath
  always_comb begin
    case (bus_sel)
      BUS_AR:  bus = {4'd0, ar};
      BUS_PC:  bus = {4'd0, pc};
      BUS_DR:  bus = dr;
      BUS_AC:  bus = ac;
      BUS_IR:  bus = ir;
      BUS_TR:  bus = tr;
      BUS_MEM: bus = mem[ar];
      default: bus = '0;
    endcase
    alu_c = e;
    alu_res = ac;
    case (alu_sel)
      ALU_AND:     alu_res = ac & dr;
      ALU_ADD:     {alu_c, alu_res} = {1'b0, ac} + {1'b0, dr};
      ALU_PASS_DR: alu_res = dr;
      ALU_CMA:     alu_res = ~ac;
      ALU_CIR:     {alu_res, alu_c} = {e, ac};
      ALU_CIL:     {alu_c, alu_res} = {ac, e};
      default:     alu_res = ac;
    endcase
  end

  // Datapath registers and memory
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (memory_write) mem[ar] <= bus;
    if (AR_reset) ar <= '0; else if (AR_load) ar <= bus[11:0]; else if (AR_incr) ar <= ar + 12'd1;
    if (PC_reset) pc <= '0; else if (PC_load) pc <= bus[11:0]; else if (PC_incr) pc <= pc + 12'd1;
    if (DR_load) dr <= bus; else if (DR_incr) dr <= dr + 16'd1;
    if (ld_ac) ac <= ld_ac_val; else if (AC_reset) ac <= '0;
    else if (AC_load) ac <= alu_res; else if (AC_incr) ac <= ac + 16'd1;
    if (IR_load) ir <= bus;
    if (TR_load) tr <= bus;
    if (E_reset) e <= 1'b0; else if (E_load) e <= alu_c; else if (E_incr) e <= ~e;
    if (IEN_reset) ien <= 1'b0; else if (IEN_load) ien <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [15:0] ac0);
    @(negedge clk);
    reset_n = 1'b0; ld_ac = 1'b1; ld_ac_val = ac0;
    @(negedge clk);
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic go();
    reset_n = 1'b1; ld_ac = 1'b0;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_sc", sc_out, 0);
    check("rst_clears", {AR_reset, PC_reset, AC_reset, E_reset, IEN_reset}, 5'b11111);
    check("rst_others", {AR_load, IR_load, PC_incr, memory_write, halted, bus_sel}, 0);
    check("rst_pc", pc, 0);

    // ADD: 3 + 5
    do_reset(16'd3); load(12'h000, 16'h1010); load(12'h010, 16'h0005); go();
    check("add_t0_bus", bus_sel, BUS_PC);
    check("add_t0_arload", AR_load, 1);
    step(5);
    check("add_t5_sc", sc_out, 5);
    check("add_t5_alu", {alu_sel, AC_load, E_load}, {ALU_ADD, 2'b11});
    step(1);
    check("add_ac", ac, 16'h0008);
    check("add_e", e, 0);
    check("add_pc", pc, 1);
    check("add_sc", sc_out, 0);

    // Indirect LDA
    do_reset(16'd0); load(12'h000, 16'hA020); load(12'h020, 16'h0030); load(12'h030, 16'hBEEF); go();
    step(3);
    check("lda_t3_ind", {bus_sel, AR_load}, {BUS_MEM, 1'b1});
    step(3);
    check("lda_ac", ac, 16'hBEEF);
    check("lda_sc", sc_out, 0);

    // ISZ reaching zero skips
    do_reset(16'd0); load(12'h000, 16'h6040); load(12'h040, 16'hFFFF); go();
    step(7);
    check("isz0_mem", mem[12'h040], 16'h0000);
    check("isz0_pc", pc, 2);
    check("isz0_sc", sc_out, 0);
    // ISZ non-zero does not skip
    do_reset(16'd0); load(12'h040, 16'h0001); go();
    step(7);
    check("isz1_mem", mem[12'h040], 16'h0002);
    check("isz1_pc", pc, 1);

    // BUN 5 then BSA 0x100
    do_reset(16'd0); load(12'h000, 16'h4005); load(12'h005, 16'h5100); go();
    step(5);
    check("bun_pc", pc, 5);
    step(6);
    check("bsa_mem", mem[12'h100], 16'h0006);
    check("bsa_pc", pc, 12'h101);
    check("bsa_sc", sc_out, 0);

    // Register-reference operations
    do_reset(16'h00F0); load(12'h000, 16'h7200); go(); step(4);
    check("cma_ac", ac, 16'hFF0F);
    do_reset(16'h8001); load(12'h000, 16'h7040); go(); step(4);
    check("cil_ac", ac, 16'h0002);
    check("cil_e", e, 1);
    do_reset(16'h0000); load(12'h000, 16'h7024); go(); step(4);
    check("prio_pc", pc, 2);
    check("prio_ac", ac, 16'h0000);
    do_reset(16'h8000); load(12'h000, 16'h7010); go(); step(4);
    check("spa_pc", pc, 1);

    // HLT freezes everything
    do_reset(16'd0); load(12'h000, 16'h7001); go(); step(3);
    check("hlt_pre", halted, 0);
    step(1);
    check("hlt_set", halted, 1);
    step(20);
    check("hlt_pc", pc, 1);
    check("hlt_sc", sc_out, 0);
    check("hlt_strobes", {AR_load, PC_incr, IR_load, memory_write, bus_sel}, 0);

    // Asynchronous reset in the middle of T4, then restart
    do_reset(16'd0);
    check("hlt_cleared", halted, 0);
    load(12'h000, 16'h1010); load(12'h010, 16'h0005); go();
    step(4);
    check("mid_sc4", sc_out, 4);
    reset_n = 1'b0;
    #1;
    check("mid_sc_async", sc_out, 0);
    @(negedge clk);
    check("mid_pc", pc, 0);
    go();
    step(6);
    check("restart_ac", ac, 16'h0005);
    check("restart_pc", pc, 1);

`ifdef MBC_INTERRUPT_EN
    // ION, then an interrupt request during the following ADD
    do_reset(16'd0); load(12'h000, 16'hF080); load(12'h001, 16'h1010); load(12'h010, 16'h0005); go();
    step(4);
    check("ion_ien", ien, 1);
    fgi = 1'b1;
    step(6);
    check("int_pc_before", pc, 2);
    step(3);
    check("int_mem0", mem[12'h000], 16'h0002);
    check("int_pc", pc, 1);
    check("int_ien", ien, 0);
    fgi = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
